ex_div_unit: RTL and testbench
==============================

EX_DIV_UNIT -- requirements
Module: ex_div_unit

Interface
REQ-001 Parameter XLEN, default 64, operand/result width.
REQ-002 Parameter ITER, default 64, restoring-division iterations; SHALL equal XLEN.
REQ-003 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  EX-stage instruction held in the decode/execute register is a divide op.
REQ-006 op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 rs1_val  in  XLEN  dividend; rs2_val  in  XLEN  divisor.
REQ-008 rd_in  in  5  destination register; wbe_in  in  8  write-back enables.
REQ-009 flush  in  1  kill the in-flight operation.
REQ-010 stall_o  out  1  hold decode/execute register and upstream stages.
REQ-011 busy_o  out  1  state != IDLE.
REQ-012 done_o  out  1  one-cycle result-valid strobe.
REQ-013 result_o  out  XLEN; rd_o  out  5; wbe_o  out  8: captured with the op, valid while done_o=1.

Function
REQ-014 FSM states IDLE, RUN, DONE; the FSM SHALL be in exactly one state.
REQ-015 IDLE with start=1 and flush=0: capture op, operands, rd_in, wbe_in (accept cycle T0).
REQ-016 At accept, rs2_val==0 or (signed op and rs1_val==1<<(XLEN-1) and rs2_val==all-ones): fast path, SHALL go directly to DONE at T1.
REQ-017 Otherwise SHALL go to RUN; RUN SHALL last exactly ITER cycles (T1..T64), one quotient bit per cycle, MSB first; then DONE at T65.
REQ-018 DONE SHALL last one cycle with done_o=1, then IDLE; start seen in DONE SHALL be ignored (same instruction).
REQ-019 stall_o = (IDLE & start & !flush) | RUN; stall_o SHALL be 0 in DONE.
REQ-020 Signed ops: divide magnitudes; quotient negated iff operand signs differ; remainder takes sign of dividend.
REQ-021 Divide by zero: quotient all-ones, remainder = rs1_val.
REQ-022 Signed overflow: quotient = rs1_val, remainder = 0.
REQ-023 result_o = quotient for DIV/DIVU, remainder for REM/REMU; truncated to XLEN bits.
REQ-024 result_o, rd_o, wbe_o SHALL be 0 when done_o=0.
REQ-025 flush=1 in any state: next state IDLE, no done_o for that op; flush has priority over start.
REQ-026 rd_in==0 SHALL still compute normally; rd_o=0 returned unchanged.

Reset
REQ-027 rst=1 at a clock edge: state IDLE; all outputs 0 the following cycle; in-flight op discarded.
REQ-028 rst SHALL take priority over flush and start.
REQ-029 Internal datapath registers SHALL be cleared to 0 on reset.

Structure
REQ-030 Shared package riscv_div_pkg: XLEN, op encodings DIV/DIVU/REM/REMU, FSM state enum.
REQ-031 One sub-module div_step: combinational single restoring iteration (shift remainder, trial subtract, quotient bit).
REQ-032 Sign fix-up and fast-path detection SHALL live in ex_div_unit.

Verification
REQ-033 DIVU 100/7, start at T0 -> stall_o=1 T0..T64, done_o=1 at T65, result_o=14, rd_o=rd_in.
REQ-034 DIV -7/2 -> result_o=0xFFFF_FFFF_FFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 7/2 -> 1.
REQ-035 DIVU 5/0 -> done_o at T1, result all-ones; REM 5/0 -> done_o at T1, result 5.
REQ-036 DIV 0x8000_0000_0000_0000 / all-ones -> done_o at T1, result 0x8000_0000_0000_0000; REM same -> 0.
REQ-037 Flush at RUN cycle T10 -> IDLE next cycle, stall_o=0, no done_o; new DIVU 9/3 then accepted -> 3.
REQ-038 rst at RUN cycle T20 -> IDLE, all outputs 0, no done_o; start held through DONE never triggers a second op.

Source files
------------

// File: rtl/ex_div_unit_pkg.sv
// rtl/ex_div_unit_pkg.sv - shared divider constants, op encodings and FSM states
package riscv_div_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

  // op[0]=0 selects the signed variants, op[1]=1 selects the remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_div_unit_if.sv
// rtl/ex_div_unit_if.sv - EX-stage request / divider response bundle
interface ex_div_unit_if #(parameter int XLEN = riscv_div_pkg::XLEN);

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic [7:0]      wbe_in;
  logic            flush;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;
  logic [7:0]      wbe_o;

  modport master (
    output start, op, rs1_val, rs2_val, rd_in, wbe_in, flush,
    input  stall_o, busy_o, done_o, result_o, rd_o, wbe_o
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, rd_in, wbe_in, flush,
    output stall_o, busy_o, done_o, result_o, rd_o, wbe_o
  );

endinterface

// File: rtl/ex_div_unit_step.sv
// rtl/ex_div_unit_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] dividend_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          qbit;

  // Quotient bits shift into the dividend register as its bits are consumed.
  always_comb begin
    shifted    = {rem_i, dividend_i[XLEN-1]};
    diff       = shifted - {1'b0, divisor_i};
    qbit       = ~diff[XLEN];
    rem_o      = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    dividend_o = {dividend_i[XLEN-2:0], qbit};
  end

endmodule

// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - multi-cycle EX-stage integer divider (DIV/DIVU/REM/REMU)
module ex_div_unit #(
  parameter int XLEN = riscv_div_pkg::XLEN,
  parameter int ITER = XLEN
) (
  input  logic         clk,
  input  logic         rst,
  ex_div_unit_if.slave bus
);

  import riscv_div_pkg::*;

  localparam int CW = $clog2(ITER + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q;
  logic            is_rem_q;
  logic            qneg_q;
  logic            rneg_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_q;
  logic [7:0]      wbe_q;
  logic [CW-1:0]   cnt_q;

  logic            sgn;
  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] fix_q;
  logic [XLEN-1:0] fix_r;
  logic [XLEN-1:0] run_res;

  always_comb begin
    sgn      = op_is_signed(bus.op);
    rs1_neg  = sgn & bus.rs1_val[XLEN-1];
    rs2_neg  = sgn & bus.rs2_val[XLEN-1];
    a_mag    = rs1_neg ? -bus.rs1_val : bus.rs1_val;
    b_mag    = rs2_neg ? -bus.rs2_val : bus.rs2_val;
    div_zero = (bus.rs2_val == '0);
    ovf      = sgn & (bus.rs1_val == SMIN) & (bus.rs2_val == '1);
    // Divide-by-zero and signed overflow bypass the iteration entirely.
    if (div_zero) begin
      fast_res = op_is_rem(bus.op) ? bus.rs1_val : '1;
    end else begin
      fast_res = op_is_rem(bus.op) ? '0 : bus.rs1_val;
    end
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i      (rem_q),
    .dividend_i (dvd_q),
    .divisor_i  (dvs_q),
    .rem_o      (step_rem),
    .dividend_o (step_quo)
  );

  always_comb begin
    fix_q   = qneg_q ? -step_quo : step_quo;
    fix_r   = rneg_q ? -step_rem : step_rem;
    run_res = is_rem_q ? fix_r : fix_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      wbe_q    <= '0;
      cnt_q    <= '0;
    end else if (bus.flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            is_rem_q <= op_is_rem(bus.op);
            qneg_q   <= rs1_neg ^ rs2_neg;
            rneg_q   <= rs1_neg;
            dvd_q    <= a_mag;
            dvs_q    <= b_mag;
            rem_q    <= '0;
            rd_q     <= bus.rd_in;
            wbe_q    <= bus.wbe_in;
            cnt_q    <= '0;
            if (div_zero || ovf) begin
              result_q <= fast_res;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          rem_q <= step_rem;
          dvd_q <= step_quo;
          cnt_q <= cnt_q + 1'b1;
          // The final iteration's outputs feed the sign fix-up directly.
          if (cnt_q == CW'(ITER - 1)) begin
            result_q <= run_res;
            state_q  <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_o  = ((state_q == S_IDLE) & bus.start & ~bus.flush) | (state_q == S_RUN);
  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.done_o   = (state_q == S_DONE);
  assign bus.result_o = (state_q == S_DONE) ? result_q : '0;
  assign bus.rd_o     = (state_q == S_DONE) ? rd_q : '0;
  assign bus.wbe_o    = (state_q == S_DONE) ? wbe_q : '0;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - self-checking bench for ex_div_unit
module tb_ex_div_unit;

  import riscv_div_pkg::*;

  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_div_unit_if #(.XLEN(64)) bus();

  ex_div_unit #(.XLEN(64), .ITER(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [7:0]  wbe;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic        sgn;
    logic [63:0] q;
    logic [63:0] r;
    sgn = !op[0];
    if (b == 64'd0) begin
      q = ONES;
      r = a;
    end else if (sgn && a == MIN && b == ONES) begin
      q = a;
      r = 64'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    if (b == 64'd0 || (!op[0] && a == MIN && b == ONES)) return 1;
    return 65;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [7:0] wbe,
                       output int lat, output logic [63:0] res, output logic [4:0] rdo,
                       output logic [7:0] wbeo, output int stall_bad);
    lat = -1;
    res = '0;
    rdo = '0;
    wbeo = '0;
    stall_bad = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in = rd;
    bus.wbe_in = wbe;
    @(negedge clk);
    if (!bus.stall_o) stall_bad++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      if (bus.done_o) begin
        lat = t;
        res = bus.result_o;
        rdo = bus.rd_o;
        wbeo = bus.wbe_o;
        if (bus.stall_o) stall_bad++;
        break;
      end
      if (!bus.stall_o) stall_bad++;
    end
  endtask

  task automatic watch(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done_o) seen++;
    end
  endtask

  task automatic run_one(input string tag, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input logic [7:0] wbe,
                         input logic [63:0] exp, input int exp_lat);
    int          lat;
    int          sb;
    logic [63:0] res;
    logic [4:0]  rdo;
    logic [7:0]  wbeo;
    do_op(op, a, b, rd, wbe, lat, res, rdo, wbeo, sb);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, res, exp);
    chk({tag, " rd"}, 64'(rdo), 64'(rd));
    chk({tag, " wbe"}, 64'(wbeo), 64'(wbe));
    chk({tag, " stall"}, 64'(sb), 64'd0);
  endtask

  initial begin
    int seen;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_in = '0;
    bus.wbe_in = '0;
    bus.flush = 1'b0;

    vecs[0]  = '{OP_DIVU, 64'd100, 64'd7, 5'd3, 8'hFF, 64'd14, 65};
    vecs[1]  = '{OP_DIV, -64'd7, 64'd2, 5'd4, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[2]  = '{OP_REM, -64'd7, 64'd2, 5'd5, 8'h01, ONES, 65};
    vecs[3]  = '{OP_REMU, 64'd7, 64'd2, 5'd6, 8'h80, 64'd1, 65};
    vecs[4]  = '{OP_DIVU, 64'd5, 64'd0, 5'd7, 8'h33, ONES, 1};
    vecs[5]  = '{OP_REM, 64'd5, 64'd0, 5'd8, 8'h55, 64'd5, 1};
    vecs[6]  = '{OP_DIV, MIN, ONES, 5'd9, 8'hAA, MIN, 1};
    vecs[7]  = '{OP_REM, MIN, ONES, 5'd10, 8'hF0, 64'd0, 1};
    vecs[8]  = '{OP_DIVU, 64'd9, 64'd3, 5'd0, 8'hFF, 64'd3, 65};
    vecs[9]  = '{OP_DIV, 64'd7, -64'd2, 5'd11, 8'h01, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[10] = '{OP_REM, 64'd7, -64'd2, 5'd12, 8'h02, 64'd1, 65};
    vecs[11] = '{OP_DIVU, ONES, ONES, 5'd13, 8'h04, 64'd1, 65};
    vecs[12] = '{OP_DIVU, MIN, ONES, 5'd14, 8'h08, 64'd0, 65};
    vecs[13] = '{OP_DIVU, 64'd0, 64'd5, 5'd31, 8'h10, 64'd0, 65};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 64'(bus.busy_o), 64'd0);
    chk("reset done", 64'(bus.done_o), 64'd0);
    chk("reset stall", 64'(bus.stall_o), 64'd0);
    chk("reset result", bus.result_o, 64'd0);
    chk("reset rd", 64'(bus.rd_o), 64'd0);
    chk("reset wbe", 64'(bus.wbe_o), 64'd0);

    for (int i = 0; i < 14; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
              vecs[i].wbe, vecs[i].exp, vecs[i].lat);
    end

    // Flush mid-iteration, then a fresh operation.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1_val = 64'd100; bus.rs2_val = 64'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush stall", 64'(bus.stall_o), 64'd0);
    chk("flush busy", 64'(bus.busy_o), 64'd0);
    watch(80, seen);
    chk("flush no done", 64'(seen), 64'd0);
    run_one("after flush", OP_DIVU, 64'd9, 64'd3, 5'd2, 8'hFF, 64'd3, 65);

    // Reset mid-iteration.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_DIV; bus.rs1_val = 64'd1000; bus.rs2_val = 64'd3;
    bus.rd_in = 5'd17; bus.wbe_in = 8'hFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst busy", 64'(bus.busy_o), 64'd0);
    chk("rst stall", 64'(bus.stall_o), 64'd0);
    chk("rst done", 64'(bus.done_o), 64'd0);
    chk("rst result", bus.result_o, 64'd0);
    chk("rst rd", 64'(bus.rd_o), 64'd0);
    chk("rst wbe", 64'(bus.wbe_o), 64'd0);
    watch(80, seen);
    chk("rst no done", 64'(seen), 64'd0);

    // Start held through DONE must not launch a second op.
    begin
      int got;
      got = 0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1_val = 64'd6; bus.rs2_val = 64'd3;
      bus.rd_in = 5'd21; bus.wbe_in = 8'h3C;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (bus.done_o) begin
          got = 1;
          chk("held result", bus.result_o, 64'd2);
          chk("held done stall", 64'(bus.stall_o), 64'd0);
          break;
        end
      end
      chk("held done seen", 64'(got), 64'd1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      watch(80, seen);
      chk("held no second", 64'(seen), 64'd0);
      chk("held idle", 64'(bus.busy_o), 64'd0);
    end

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = {$urandom, $urandom};
        1: a = 64'($urandom_range(0, 1000));
        2: a = MIN;
        default: a = ONES - 64'($urandom_range(0, 5));
      endcase
      case ($urandom_range(0, 4))
        0: b = {$urandom, $urandom};
        1: b = 64'($urandom_range(1, 50));
        2: b = 64'd0;
        3: b = ONES;
        default: b = {32'd0, $urandom};
      endcase
      run_one($sformatf("rand%0d", i), op, a, b, 5'($urandom), 8'($urandom),
              model(op, a, b), model_lat(op, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
